// File: rtl/hazard_control_unit.sv
// Hazard controller between ID and EX: load-use stall detection,
// branch/jump flush sequencing, and saturating stall/flush statistics.
module hazard_control_unit #(
   parameter int REG_ADDR_W         = 4,
   parameter int LOAD_LATENCY       = 1,
   parameter int FLUSH_CYCLES       = 1,
   parameter int ZERO_REG_HARDWIRED = 1,
   parameter int STAT_W             = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_memread,
   input  logic                  ex_branch,
   input  logic                  ex_branch_ne,
   input  logic                  ex_zero,
   input  logic                  ex_jump,
   output logic                  pc_write_en,
   output logic                  ifid_write_en,
   output logic                  idex_bubble,
   output logic                  flush_ifid,
   output logic                  flush_idex,
   output logic [STAT_W-1:0]     stall_cycles,
   output logic [STAT_W-1:0]     flush_events
);

   localparam int MAX_HOLD = (LOAD_LATENCY > FLUSH_CYCLES) ? LOAD_LATENCY : FLUSH_CYCLES;
   localparam int CNT_W    = $clog2(MAX_HOLD) + 1;

   typedef enum logic [1:0] {RUN, LOAD_STALL, FLUSH} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             rd_is_zero, hit1, hit2, load_use, taken, apply_taken;

   // Saturating increment: holds at all-ones instead of wrapping
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + STAT_W'(1);
   endfunction

   assign rd_is_zero = (ZERO_REG_HARDWIRED != 0) && (ex_rd == '0);
   assign hit1       = id_rs1_used && (id_rs1 == ex_rd) && !rd_is_zero;
   assign hit2       = id_rs2_used && (id_rs2 == ex_rd) && !rd_is_zero;
   assign load_use   = ex_memread && (hit1 || hit2);
   assign taken      = ex_jump || (ex_branch && (ex_branch_ne ? !ex_zero : ex_zero));

   // Same-cycle hazard response and next-state selection; reset forces outputs inactive
   always_comb begin
      pc_write_en   = 1'b1;
      ifid_write_en = 1'b1;
      idex_bubble   = 1'b0;
      flush_ifid    = 1'b0;
      flush_idex    = 1'b0;
      apply_taken   = 1'b0;
      state_nxt     = state;
      cnt_nxt       = cnt;
      case (state)
         RUN, LOAD_STALL: begin
            if (taken) begin
               // a flush always wins and aborts any stall in progress
               flush_ifid  = 1'b1;
               flush_idex  = 1'b1;
               apply_taken = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_nxt = FLUSH;
                  cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
               end else begin
                  state_nxt = RUN;
                  cnt_nxt   = '0;
               end
            end else if (state == LOAD_STALL) begin
               pc_write_en   = 1'b0;
               ifid_write_en = 1'b0;
               idex_bubble   = 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state_nxt = RUN;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt - CNT_W'(1);
               end
            end else if (load_use) begin
               pc_write_en   = 1'b0;
               ifid_write_en = 1'b0;
               idex_bubble   = 1'b1;
               if (LOAD_LATENCY > 1) begin
                  state_nxt = LOAD_STALL;
                  cnt_nxt   = CNT_W'(LOAD_LATENCY - 1);
               end
            end
         end
         FLUSH: begin
            flush_ifid = 1'b1;
            if (taken) begin
               // a fresh branch/jump restarts the flush window
               flush_idex  = 1'b1;
               apply_taken = 1'b1;
               cnt_nxt     = CNT_W'(FLUSH_CYCLES - 1);
            end else if (cnt == CNT_W'(1)) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = RUN;
            cnt_nxt   = '0;
         end
      endcase
      if (reset) begin
         pc_write_en   = 1'b1;
         ifid_write_en = 1'b1;
         idex_bubble   = 1'b0;
         flush_ifid    = 1'b0;
         flush_idex    = 1'b0;
         apply_taken   = 1'b0;
      end
   end

   // State, hold counter and statistics registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= RUN;
         cnt          <= '0;
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (!pc_write_en) stall_cycles <= sat_inc(stall_cycles);
         if (apply_taken)  flush_events <= sat_inc(flush_events);
      end
   end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit across four parameter sets.
module tb_hazard_control_unit;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] id_rs1, id_rs2, ex_rd;
   logic       id_rs1_used, id_rs2_used, ex_memread, ex_branch, ex_branch_ne, ex_zero, ex_jump;

   logic        pc0, if0, bb0, fi0, fx0;
   logic [15:0] sc0, fe0;
   logic        pc1, if1, bb1, fi1, fx1;
   logic [15:0] sc1, fe1;
   logic        pc2, if2, bb2, fi2, fx2;
   logic [15:0] sc2, fe2;
   logic        pc3, if3, bb3, fi3, fx3;
   logic [1:0]  sc3, fe3;

   int passed = 0;
   int total  = 0;

   always #5 clock = ~clock;

   // defaults
   hazard_control_unit u0 (
      .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
      .ex_memread(ex_memread), .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne),
      .ex_zero(ex_zero), .ex_jump(ex_jump), .pc_write_en(pc0), .ifid_write_en(if0),
      .idex_bubble(bb0), .flush_ifid(fi0), .flush_idex(fx0),
      .stall_cycles(sc0), .flush_events(fe0));

   // register zero not hardwired
   hazard_control_unit #(.ZERO_REG_HARDWIRED(0)) u1 (
      .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
      .ex_memread(ex_memread), .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne),
      .ex_zero(ex_zero), .ex_jump(ex_jump), .pc_write_en(pc1), .ifid_write_en(if1),
      .idex_bubble(bb1), .flush_ifid(fi1), .flush_idex(fx1),
      .stall_cycles(sc1), .flush_events(fe1));

   // multi-cycle holds
   hazard_control_unit #(.LOAD_LATENCY(3), .FLUSH_CYCLES(2)) u2 (
      .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
      .ex_memread(ex_memread), .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne),
      .ex_zero(ex_zero), .ex_jump(ex_jump), .pc_write_en(pc2), .ifid_write_en(if2),
      .idex_bubble(bb2), .flush_ifid(fi2), .flush_idex(fx2),
      .stall_cycles(sc2), .flush_events(fe2));

   // narrow statistics
   hazard_control_unit #(.STAT_W(2)) u3 (
      .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
      .ex_memread(ex_memread), .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne),
      .ex_zero(ex_zero), .ex_jump(ex_jump), .pc_write_en(pc3), .ifid_write_en(if3),
      .idex_bubble(bb3), .flush_ifid(fi3), .flush_idex(fx3),
      .stall_cycles(sc3), .flush_events(fe3));

   typedef struct {
      string      name;
      logic [3:0] rs1, rs2, rd;
      logic       u1, u2, mr, br, bne, z, j;
      logic       pc, ifid, bub, fi, fx;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clr();
      id_rs1 = 4'd0; id_rs2 = 4'd0; ex_rd = 4'd0;
      id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_memread = 1'b0;
      ex_branch = 1'b0; ex_branch_ne = 1'b0; ex_zero = 1'b0; ex_jump = 1'b0;
   endtask

   task automatic set_lu();
      ex_memread = 1'b1; ex_rd = 4'd3; id_rs2 = 4'd3; id_rs2_used = 1'b1;
   endtask

   task automatic do_reset();
      clr();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
   endtask

   initial begin
      int exp_stall, exp_flush;
      //                 name        rs1   rs2   rd    u1 u2 mr br bne z  j   pc if bb fi fx
      vecs[0]  = '{"no_hit",    4'd1, 4'd2, 4'd3, 1, 1, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0};
      vecs[1]  = '{"rs2_hit",   4'd1, 4'd3, 4'd3, 1, 1, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0};
      vecs[2]  = '{"rs1_hit",   4'd5, 4'd2, 4'd5, 1, 0, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0};
      vecs[3]  = '{"rs1_unused",4'd5, 4'd2, 4'd5, 0, 1, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0};
      vecs[4]  = '{"not_load",  4'd5, 4'd5, 4'd5, 1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0};
      vecs[5]  = '{"zero_reg",  4'd0, 4'd0, 4'd0, 1, 1, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0};
      vecs[6]  = '{"beq_taken", 4'd0, 4'd0, 4'd1, 0, 0, 0, 1, 0, 1, 0,  1, 1, 0, 1, 1};
      vecs[7]  = '{"beq_not",   4'd0, 4'd0, 4'd1, 0, 0, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0};
      vecs[8]  = '{"bne_taken", 4'd0, 4'd0, 4'd1, 0, 0, 0, 1, 1, 0, 0,  1, 1, 0, 1, 1};
      vecs[9]  = '{"bne_not",   4'd0, 4'd0, 4'd1, 0, 0, 0, 1, 1, 1, 0,  1, 1, 0, 0, 0};
      vecs[10] = '{"jump_lu",   4'd7, 4'd7, 4'd7, 1, 1, 1, 0, 0, 0, 1,  1, 1, 0, 1, 1};
      vecs[11] = '{"jump",      4'd0, 4'd0, 4'd2, 0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 1, 1};

      clr();
      reset = 1'b1;
      set_lu();
      ex_jump = 1'b1;
      tick();
      chk("rst_pc", pc0, 1); chk("rst_bub", bb0, 0); chk("rst_fi", fi0, 0);
      chk("rst_fx", fx0, 0); chk("rst_sc", sc0, 0); chk("rst_fe", fe0, 0);
      reset = 1'b0;
      clr();
      #1;

      // combinational response of the default configuration
      exp_stall = 0;
      exp_flush = 0;
      for (int i = 0; i < 12; i++) begin
         id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; ex_rd = vecs[i].rd;
         id_rs1_used = vecs[i].u1; id_rs2_used = vecs[i].u2; ex_memread = vecs[i].mr;
         ex_branch = vecs[i].br; ex_branch_ne = vecs[i].bne; ex_zero = vecs[i].z;
         ex_jump = vecs[i].j;
         #1;
         chk({vecs[i].name, "_pc"}, pc0, vecs[i].pc);
         chk({vecs[i].name, "_ifid"}, if0, vecs[i].ifid);
         chk({vecs[i].name, "_bub"}, bb0, vecs[i].bub);
         chk({vecs[i].name, "_fi"}, fi0, vecs[i].fi);
         chk({vecs[i].name, "_fx"}, fx0, vecs[i].fx);
         if (!vecs[i].pc) exp_stall++;
         if (vecs[i].fx) exp_flush++;
         tick();
      end
      chk("tbl_stall_cnt", sc0, exp_stall);
      chk("tbl_flush_cnt", fe0, exp_flush);

      // register zero hazard when not hardwired
      do_reset();
      ex_memread = 1'b1; id_rs1_used = 1'b1;
      #1;
      chk("zr0_u0_pc", pc0, 1);
      chk("zr0_u1_pc", pc1, 0);
      tick();
      clr();
      #1;
      chk("zr0_u1_release", pc1, 1);
      chk("zr0_u1_sc", sc1, 1);

      // one-cycle stall in the default configuration
      do_reset();
      set_lu();
      #1;
      chk("lu1_pc", pc0, 0); chk("lu1_bub", bb0, 1);
      tick();
      clr();
      #1;
      chk("lu1_after_pc", pc0, 1); chk("lu1_sc", sc0, 1);

      // three-cycle stall from a single-cycle hazard pulse
      do_reset();
      set_lu();
      #1;
      chk("lu3_c1_pc", pc2, 0);
      tick();
      clr();
      #1;
      chk("lu3_c2_pc", pc2, 0); chk("lu3_c2_ifid", if2, 0); chk("lu3_c2_bub", bb2, 1);
      tick();
      chk("lu3_c3_pc", pc2, 0);
      tick();
      chk("lu3_c4_pc", pc2, 1); chk("lu3_c4_bub", bb2, 0); chk("lu3_sc", sc2, 3);

      // two-cycle flush on a taken bne
      do_reset();
      ex_branch = 1'b1; ex_branch_ne = 1'b1; ex_zero = 1'b0;
      #1;
      chk("fl2_c1_fi", fi2, 1); chk("fl2_c1_fx", fx2, 1); chk("fl2_c1_pc", pc2, 1);
      tick();
      clr();
      #1;
      chk("fl2_c2_fi", fi2, 1); chk("fl2_c2_fx", fx2, 0); chk("fl2_c2_ifid", if2, 1);
      tick();
      chk("fl2_c3_fi", fi2, 0); chk("fl2_fe", fe2, 1);
      ex_branch = 1'b1; ex_branch_ne = 1'b1; ex_zero = 1'b1;
      #1;
      chk("fl2_nt_fi", fi2, 0);
      tick();
      chk("fl2_nt_fe", fe2, 1);
      clr();

      // new branch during flush restarts the window
      do_reset();
      ex_jump = 1'b1;
      tick();
      #1;
      chk("refl_fx", fx2, 1); chk("refl_fi", fi2, 1);
      tick();
      clr();
      #1;
      chk("refl_c3_fi", fi2, 1); chk("refl_c3_fx", fx2, 0); chk("refl_fe", fe2, 2);
      tick();
      chk("refl_c4_fi", fi2, 0);

      // load-use with jump in the same cycle
      do_reset();
      set_lu();
      ex_jump = 1'b1;
      #1;
      chk("lujmp_pc", pc2, 1); chk("lujmp_fi", fi2, 1); chk("lujmp_bub", bb2, 0);
      tick();
      clr();
      #1;
      chk("lujmp_sc", sc2, 0); chk("lujmp_fe", fe2, 1);

      // taken in the second cycle of a three-cycle stall
      do_reset();
      set_lu();
      tick();
      clr();
      ex_jump = 1'b1;
      #1;
      chk("abort_pc", pc2, 1); chk("abort_fi", fi2, 1); chk("abort_fx", fx2, 1);
      tick();
      clr();
      #1;
      chk("abort_c3_pc", pc2, 1); chk("abort_c3_fi", fi2, 1); chk("abort_c3_fx", fx2, 0);
      tick();
      chk("abort_c4_fi", fi2, 0); chk("abort_c4_pc", pc2, 1);
      chk("abort_sc", sc2, 1); chk("abort_fe", fe2, 1);

      // saturation of a two-bit counter
      do_reset();
      set_lu();
      for (int i = 0; i < 5; i++) tick();
      clr();
      #1;
      chk("sat_sc", sc3, 3); chk("nosat_sc", sc0, 5);

      // asynchronous reset in the middle of a stall
      do_reset();
      set_lu();
      tick();
      chk("rstmid_pre_pc", pc2, 0);
      reset = 1'b1;
      #1;
      chk("rstmid_pc", pc2, 1); chk("rstmid_bub", bb2, 0); chk("rstmid_sc", sc2, 0);
      clr();
      #1;
      reset = 1'b0;
      #1;
      chk("rstmid_run_pc", pc2, 1);
      tick();
      chk("rstmid_run2_pc", pc2, 1); chk("rstmid_run2_sc", sc2, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule
